// File: rtl/cpu_pixel_wr_fifo_pio_pkg.sv
// Shared definitions for the CPU pixel-write PIO block: register map,
// STATUS/CONTROL bit positions and a STATUS word packing helper.
package cpu_pio_pkg;

  // Avalon-MM register offsets (word addresses)
  typedef enum logic [1:0] {
    REG_DATA     = 2'd0,
    REG_STATUS   = 2'd1,
    REG_CONTROL  = 2'd2,
    REG_IRQ_MASK = 2'd3
  } reg_addr_e;

  // STATUS bit positions; the fill level occupies [15:0]
  localparam int STATUS_OVF_BIT   = 18;
  localparam int STATUS_FULL_BIT  = 17;
  localparam int STATUS_EMPTY_BIT = 16;

  // CONTROL bit positions
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_FLUSH_BIT  = 1;

  // IRQ_MASK bit positions
  localparam int MASK_EMPTY_BIT = 0;
  localparam int MASK_OVF_BIT   = 1;

  // Build the STATUS read word from the individual flags and level
  function automatic logic [31:0] pack_status(input logic        ovf,
                                              input logic        full,
                                              input logic        empty,
                                              input logic [15:0] level);
    logic [31:0] w;
    w                   = '0;
    w[STATUS_OVF_BIT]   = ovf;
    w[STATUS_FULL_BIT]  = full;
    w[STATUS_EMPTY_BIT] = empty;
    w[15:0]             = level;
    return w;
  endfunction

endpackage

// File: rtl/cpu_pixel_wr_fifo_pio_if.sv
// Bus bundle for the PIO block: Avalon-MM slave side towards the CPU and
// the valid/ready stream towards the panel writer.
interface cpu_pixel_wr_fifo_pio_if #(
  parameter int DATA_W = 24
);
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              irq;

  // Driver side: CPU bus master plus the panel writer's ready
  modport master (
    output address, chipselect, write_n, writedata, out_ready,
    input  readdata, out_data, out_valid, irq
  );

  // The PIO block itself
  modport slave (
    input  address, chipselect, write_n, writedata, out_ready,
    output readdata, out_data, out_valid, irq
  );
endinterface

// File: rtl/cpu_pixel_wr_fifo_pio_sync_fifo.sv
// Single-clock FIFO with fall-through head output. Storage is not reset;
// the head reads as zero whenever the FIFO is empty so nothing stale leaks.
module cpu_pio_sync_fifo #(
  parameter  int DATA_W = 24,
  parameter  int DEPTH  = 16,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty,
  output logic              drop
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_W'(DEPTH));
  assign level = level_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // Accept/drop decisions and next pointer/level; flush overrides everything
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && !flush && (!full || do_pop);
    drop     = push && full && !do_pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write; no reset so it maps onto plain RAM/registers
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/cpu_pixel_wr_fifo_pio.sv
// CPU-to-panel pixel write PIO: Avalon-MM register decode, LAST/overflow/
// enable/mask registers and the interrupt, wrapped around the sync FIFO.
module cpu_pixel_wr_fifo_pio
  import cpu_pio_pkg::*;
#(
  parameter  int DATA_W = 24,
  parameter  int DEPTH  = 16,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input logic                    clk,
  input logic                    reset_n,
  cpu_pixel_wr_fifo_pio_if.slave bus
);

  logic              wr_en;
  reg_addr_e         addr;
  logic [DATA_W-1:0] last_q, last_d;
  logic              ovf_q, ovf_d;
  logic              enable_q, enable_d;
  logic [1:0]        mask_q, mask_d;
  logic              push, pop, flush, drop;
  logic              full, empty;
  logic [LVL_W-1:0]  level;
  logic [DATA_W-1:0] head;
  logic              unused_wdata;

  assign wr_en = bus.chipselect && !bus.write_n;
  assign addr  = reg_addr_e'(bus.address);

  // Bits above DATA_W and unmapped register bits are ignored on write
  assign unused_wdata = ^bus.writedata;

  assign bus.out_valid = !empty && enable_q;
  assign bus.out_data  = head;
  assign pop           = bus.out_valid && bus.out_ready;

  // Interrupt is a pure function of registered state, never of the bus
  assign bus.irq = (mask_q[MASK_EMPTY_BIT] && empty) || (mask_q[MASK_OVF_BIT] && ovf_q);

  cpu_pio_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (bus.writedata[DATA_W-1:0]),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty),
    .drop  (drop)
  );

  // Register write decode; a dropped push sets the sticky overflow flag
  always_comb begin
    last_d   = last_q;
    ovf_d    = ovf_q;
    enable_d = enable_q;
    mask_d   = mask_q;
    push     = 1'b0;
    flush    = 1'b0;
    if (wr_en) begin
      case (addr)
        REG_DATA: begin
          push   = 1'b1;
          last_d = bus.writedata[DATA_W-1:0];
        end
        REG_STATUS: begin
          if (bus.writedata[STATUS_OVF_BIT]) ovf_d = 1'b0;
        end
        REG_CONTROL: begin
          enable_d = bus.writedata[CTRL_ENABLE_BIT];
          flush    = bus.writedata[CTRL_FLUSH_BIT];
        end
        REG_IRQ_MASK: begin
          mask_d = bus.writedata[1:0];
        end
        default: ;
      endcase
    end
    if (drop) ovf_d = 1'b1;
  end

  // Control/status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q   <= '0;
      ovf_q    <= 1'b0;
      enable_q <= 1'b0;
      mask_q   <= '0;
    end else begin
      last_q   <= last_d;
      ovf_q    <= ovf_d;
      enable_q <= enable_d;
      mask_q   <= mask_d;
    end
  end

  // Side-effect-free read mux, zero-extended to 32 bits
  always_comb begin
    bus.readdata = '0;
    case (addr)
      REG_DATA:     bus.readdata = 32'(last_q);
      REG_STATUS:   bus.readdata = pack_status(ovf_q, full, empty, 16'(level));
      REG_CONTROL:  bus.readdata[CTRL_ENABLE_BIT] = enable_q;
      REG_IRQ_MASK: bus.readdata[1:0] = mask_q;
      default:      bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cpu_pixel_wr_fifo_pio.sv
// Directed self-checking bench for cpu_pixel_wr_fifo_pio (DATA_W=24, DEPTH=16).
module tb_cpu_pixel_wr_fifo_pio;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  cpu_pixel_wr_fifo_pio_if #(.DATA_W(24)) bus_if ();

  cpu_pixel_wr_fifo_pio #(
    .DATA_W (24),
    .DEPTH  (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one write cycle; inputs change 1ns after the edge
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    $display("wr addr=%0d data=%08h", a, d);
  endtask

  // Combinational read, no clock edge consumed
  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus_if.address    = a;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    #1;
    d = bus_if.readdata;
    bus_if.chipselect = 1'b0;
    $display("rd addr=%0d data=%08h", a, d);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0;
    bus_if.out_ready  = 1'b0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.address    = 2'd0;
    bus_if.writedata  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus_if.out_valid); end
    checks++; if (bus_if.out_data !== 24'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 000000", bus_if.out_data); end
    checks++; if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", bus_if.irq); end
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h0001_0000) begin errors++; $display("FAIL reset_status: got %h expected 00010000", rd); end
    bus_read(2'd2, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_control: got %h expected 00000000", rd); end
    bus_read(2'd3, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_mask: got %h expected 00000000", rd); end
    bus_read(2'd0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_last: got %h expected 00000000", rd); end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [31:0] rd;
    bus_write(2'd2, 32'h1);
    bus_if.out_ready = 1'b1;
    bus_write(2'd0, 32'h00A1_B2C3);
    checks++; if (bus_if.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bus_if.out_valid); end
    checks++; if (bus_if.out_data !== 24'hA1B2C3) begin errors++; $display("FAIL single_data: got %h expected a1b2c3", bus_if.out_data); end
    @(posedge clk);
    #1;
    checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", bus_if.out_valid); end
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h0001_0000) begin errors++; $display("FAIL single_status: got %h expected 00010000", rd); end
    bus_read(2'd0, rd);
    checks++; if (rd !== 32'h00A1_B2C3) begin errors++; $display("FAIL single_last: got %h expected 00a1b2c3", rd); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    bus_if.out_ready = 1'b0;
    bus_write(2'd2, 32'h0);
    for (int i = 0; i < 17; i++) bus_write(2'd0, 32'(i));
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h0006_0010) begin errors++; $display("FAIL ovf_status: got %h expected 00060010", rd); end
    bus_read(2'd0, rd);
    checks++; if (rd !== 32'h0000_0010) begin errors++; $display("FAIL ovf_last: got %h expected 00000010", rd); end
    checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL ovf_disabled_valid: got %b expected 0", bus_if.out_valid); end
    bus_write(2'd1, 32'h0004_0000);
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h0002_0010) begin errors++; $display("FAIL ovf_clear: got %h expected 00020010", rd); end
  endtask

  task automatic test_full_pop();
    logic [31:0] rd;
    logic [23:0] exp_data;
    bus_if.out_ready = 1'b1;
    bus_write(2'd2, 32'h1);
    checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 24'h0) begin errors++; $display("FAIL fullpop_head: got %b/%h expected 1/000000", bus_if.out_valid, bus_if.out_data); end
    bus_write(2'd0, 32'h0000_0100);
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h0002_0010) begin errors++; $display("FAIL fullpop_status: got %h expected 00020010", rd); end
    for (int i = 0; i < 16; i++) begin
      exp_data = (i < 15) ? 24'(i + 1) : 24'h000100;
      checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== exp_data) begin errors++; $display("FAIL fullpop_order[%0d]: got %b/%h expected 1/%h", i, bus_if.out_valid, bus_if.out_data, exp_data); end
      @(posedge clk);
      #1;
    end
    checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL fullpop_drained: got %b expected 0", bus_if.out_valid); end
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h0001_0000) begin errors++; $display("FAIL fullpop_empty: got %h expected 00010000", rd); end
  endtask

  task automatic test_flush();
    logic [31:0] rd;
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) bus_write(2'd0, 32'h200 + 32'(i));
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h0000_0005) begin errors++; $display("FAIL flush_pre_level: got %h expected 00000005", rd); end
    checks++; if (bus_if.out_data !== 24'h000200) begin errors++; $display("FAIL flush_pre_head: got %h expected 000200", bus_if.out_data); end
    bus_if.out_ready = 1'b1;
    bus_write(2'd2, 32'h3);
    checks++; if (bus_if.out_valid !== 1'b0 || bus_if.out_data !== 24'h0) begin errors++; $display("FAIL flush_out: got %b/%h expected 0/000000", bus_if.out_valid, bus_if.out_data); end
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h0001_0000) begin errors++; $display("FAIL flush_status: got %h expected 00010000", rd); end
    bus_read(2'd2, rd);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL flush_control: got %h expected 00000001", rd); end
    bus_if.out_ready = 1'b0;
    bus_write(2'd0, 32'h55);
    checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 24'h000055) begin errors++; $display("FAIL flush_repush: got %b/%h expected 1/000055", bus_if.out_valid, bus_if.out_data); end
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL flush_repush_level: got %h expected 00000001", rd); end
    bus_write(2'd2, 32'h3);
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL irq_nomask: got %b expected 0", bus_if.irq); end
    bus_write(2'd3, 32'h1);
    checks++; if (bus_if.irq !== 1'b1) begin errors++; $display("FAIL irq_empty: got %b expected 1", bus_if.irq); end
    bus_write(2'd0, 32'hAA);
    checks++; if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL irq_nonempty: got %b expected 0", bus_if.irq); end
    bus_write(2'd3, 32'h2);
    checks++; if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL irq_ovf_idle: got %b expected 0", bus_if.irq); end
    for (int i = 0; i < 16; i++) bus_write(2'd0, 32'h100 + 32'(i));
    checks++; if (bus_if.irq !== 1'b1) begin errors++; $display("FAIL irq_ovf: got %b expected 1", bus_if.irq); end
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h0006_0010) begin errors++; $display("FAIL irq_status: got %h expected 00060010", rd); end
    bus_write(2'd1, 32'h0004_0000);
    checks++; if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL irq_ovf_clear: got %b expected 0", bus_if.irq); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bus_if.out_ready = 1'b0;
    bus_write(2'd0, 32'hBB);
    bus_write(2'd2, 32'h2);
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h0005_0000) begin errors++; $display("FAIL mid_flush_keeps_ovf: got %h expected 00050000", rd); end
    for (int i = 0; i < 8; i++) bus_write(2'd0, 32'h300 + 32'(i));
    bus_write(2'd2, 32'h1);
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h0004_0008) begin errors++; $display("FAIL mid_level8: got %h expected 00040008", rd); end
    checks++; if (bus_if.out_valid !== 1'b1 || bus_if.irq !== 1'b1) begin errors++; $display("FAIL mid_active: got %b/%b expected 1/1", bus_if.out_valid, bus_if.irq); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (bus_if.out_valid !== 1'b0 || bus_if.irq !== 1'b0 || bus_if.out_data !== 24'h0) begin errors++; $display("FAIL mid_async_clear: got %b/%b/%h expected 0/0/000000", bus_if.out_valid, bus_if.irq, bus_if.out_data); end
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h0001_0000) begin errors++; $display("FAIL mid_async_status: got %h expected 00010000", rd); end
    #1;
    reset_n = 1'b1;
    bus_if.out_ready = 1'b1;
    bus_write(2'd2, 32'h1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL mid_post_valid[%0d]: got %b expected 0", i, bus_if.out_valid); end
      @(posedge clk);
      #1;
    end
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h0001_0000) begin errors++; $display("FAIL mid_post_status: got %h expected 00010000", rd); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_overflow();
    test_full_pop();
    test_flush();
    test_irq();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
